// File: rtl/vending_machine_pkg.sv
// Shared types and constants for the vending machine core: states, datapath
// control word, comparator flags and the item/coin lookup tables.
package vending_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {IDLE, LOAD, COLLECT, DONE} state_t;
  typedef enum logic [1:0] {BAL_HOLD, BAL_CLR, BAL_ADD} bal_sel_t;

  localparam logic [W-1:0] PRICE_00 = 8'd15;
  localparam logic [W-1:0] PRICE_01 = 8'd20;
  localparam logic [W-1:0] PRICE_10 = 8'd30;
  localparam logic [W-1:0] PRICE_11 = 8'd45;

  localparam logic [W-1:0] COIN_00 = 8'd0;
  localparam logic [W-1:0] COIN_01 = 8'd5;
  localparam logic [W-1:0] COIN_10 = 8'd10;
  localparam logic [W-1:0] COIN_11 = 8'd25;

  typedef struct packed {
    logic     ld_item;
    logic     ld_price;
    logic     ld_coin;
    logic     ld_bal;
    bal_sel_t bal_sel;
  } dp_ctrl_t;

  typedef struct packed {
    logic lt;
    logic gt;
    logic eq;
  } cmp_t;

  function automatic logic [W-1:0] price_of(input logic [1:0] item);
    case (item)
      2'b00:   price_of = PRICE_00;
      2'b01:   price_of = PRICE_01;
      2'b10:   price_of = PRICE_10;
      default: price_of = PRICE_11;
    endcase
  endfunction

  function automatic logic [W-1:0] coin_of(input logic [1:0] coin);
    case (coin)
      2'b00:   coin_of = COIN_00;
      2'b01:   coin_of = COIN_01;
      2'b10:   coin_of = COIN_10;
      default: coin_of = COIN_11;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine_if.sv
// Front-panel / coin-acceptor / dispense bundle. The master side drives the
// requests, the vending core (slave) returns status and money values.
interface vending_machine_if;
  import vending_pkg::*;

  logic         start;
  logic [1:0]   item_sel;
  logic [1:0]   coin_sel;
  logic         done;
  logic [W-1:0] price;
  logic [W-1:0] balance;
  logic [W-1:0] change;

  modport master (output start, item_sel, coin_sel,
                  input  done, price, balance, change);
  modport slave  (input  start, item_sel, coin_sel,
                  output done, price, balance, change);
endinterface

// File: rtl/vending_machine_dp.sv
// Datapath: item/price/coin/balance registers, coin adder and the
// balance-vs-price comparator. All loads are steered by the controller.
module vending_dp
  import vending_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  dp_ctrl_t     ctrl,
  input  logic [1:0]   item_sel,
  input  logic [1:0]   coin_sel,
  output logic [W-1:0] price,
  output logic [W-1:0] balance,
  output cmp_t         cmp
);

  logic [1:0]   item_q;
  logic [W-1:0] coin_q;

  // Coin stage gives the one-cycle coin-to-balance latency; it drains to zero
  // whenever coins are not being accepted so nothing stale is ever added.
  always_ff @(posedge clk) begin
    if (reset) begin
      item_q  <= 2'b00;
      price   <= '0;
      coin_q  <= '0;
      balance <= '0;
    end else begin
      if (ctrl.ld_item)  item_q <= item_sel;
      if (ctrl.ld_price) price  <= price_of(item_q);
      coin_q <= ctrl.ld_coin ? coin_of(coin_sel) : '0;
      if (ctrl.ld_bal) begin
        case (ctrl.bal_sel)
          BAL_CLR: balance <= '0;
          BAL_ADD: balance <= balance + coin_q;
          default: balance <= balance;
        endcase
      end
    end
  end

  assign cmp.lt = (balance <  price);
  assign cmp.gt = (balance >  price);
  assign cmp.eq = (balance == price);

endmodule

// File: rtl/vending_machine.sv
// Vending machine core: controller FSM on top of vending_dp. The item is
// captured on the start-accept edge so LOAD can look its price up from a register.
module vending_machine
  import vending_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  vending_machine_if.slave  bus
);

  state_t       state, state_nxt;
  dp_ctrl_t     ctrl;
  cmp_t         cmp;
  logic         enough;
  logic [W-1:0] price, balance;

  vending_dp u_dp (
    .clk      (clk),
    .reset    (reset),
    .ctrl     (ctrl),
    .item_sel (bus.item_sel),
    .coin_sel (bus.coin_sel),
    .price    (price),
    .balance  (balance),
    .cmp      (cmp)
  );

  assign enough = (cmp.gt | cmp.eq) & ~cmp.lt;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          ctrl.ld_item = 1'b1;
          state_nxt    = LOAD;
        end
      end
      LOAD: begin
        ctrl.ld_price = 1'b1;
        ctrl.ld_bal   = 1'b1;
        ctrl.bal_sel  = BAL_CLR;
        state_nxt     = COLLECT;
      end
      COLLECT: begin
        // Once covered, the coin in flight and this cycle's coin are dropped.
        if (enough) begin
          state_nxt = DONE;
        end else begin
          ctrl.ld_coin = 1'b1;
          ctrl.ld_bal  = 1'b1;
          ctrl.bal_sel = BAL_ADD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.done    = (state == DONE);
  assign bus.price   = price;
  assign bus.balance = balance;
  assign bus.change  = (state == DONE) ? (balance - price) : '0;

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: one task per scenario, expected values
// worked out by hand from the cycle-level behaviour of the core.
module tb_vending_machine;
  import vending_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  vending_machine_if vif();

  vending_machine dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; vif.start = 1'b0; vif.coin_sel = 2'b00;
    tick();
    reset = 1'b0;
  endtask

  // Leaves the core in COLLECT with the price loaded.
  task automatic start_txn(input logic [1:0] item);
    vif.item_sel = item; vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; vif.start = 1'b0; vif.item_sel = 2'b11; vif.coin_sel = 2'b11;
    tick(); tick();
    n_chk++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0d want 0", vif.done); end
    n_chk++; if (vif.price !== 8'd0) begin n_fail++; $display("FAIL rst_price got %0d want 0", vif.price); end
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL rst_balance got %0d want 0", vif.balance); end
    n_chk++; if (vif.change !== 8'd0) begin n_fail++; $display("FAIL rst_change got %0d want 0", vif.change); end
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_state got %0d want IDLE", dut.state); end
    reset = 1'b0;
    repeat (3) tick();
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL idle_coins_balance got %0d want 0", vif.balance); end
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL idle_coins_state got %0d want IDLE", dut.state); end
    vif.coin_sel = 2'b00;
  endtask

  task automatic test_coin5();
    do_reset();
    start_txn(2'b00);
    n_chk++; if (dut.state !== COLLECT) begin n_fail++; $display("FAIL c5_state got %0d want COLLECT", dut.state); end
    n_chk++; if (vif.price !== 8'd15) begin n_fail++; $display("FAIL c5_price got %0d want 15", vif.price); end
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL c5_bal0 got %0d want 0", vif.balance); end
    vif.coin_sel = 2'b01;
    tick(); tick();
    n_chk++; if (vif.balance !== 8'd5) begin n_fail++; $display("FAIL c5_bal5 got %0d want 5", vif.balance); end
    tick();
    n_chk++; if (vif.balance !== 8'd10) begin n_fail++; $display("FAIL c5_bal10 got %0d want 10", vif.balance); end
    vif.coin_sel = 2'b00;
    tick();
    n_chk++; if (vif.balance !== 8'd15) begin n_fail++; $display("FAIL c5_bal15 got %0d want 15", vif.balance); end
    n_chk++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL c5_done_early got %0d want 0", vif.done); end
    tick();
    n_chk++; if (vif.done !== 1'b1) begin n_fail++; $display("FAIL c5_done got %0d want 1", vif.done); end
    n_chk++; if (vif.change !== 8'd0) begin n_fail++; $display("FAIL c5_change got %0d want 0", vif.change); end
  endtask

  task automatic test_coin25();
    do_reset();
    start_txn(2'b11);
    vif.coin_sel = 2'b11;
    tick(); tick();
    n_chk++; if (vif.balance !== 8'd25) begin n_fail++; $display("FAIL c25_bal25 got %0d want 25", vif.balance); end
    tick();
    n_chk++; if (vif.balance !== 8'd50) begin n_fail++; $display("FAIL c25_bal50 got %0d want 50", vif.balance); end
    n_chk++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL c25_done_early got %0d want 0", vif.done); end
    tick();
    n_chk++; if (vif.done !== 1'b1) begin n_fail++; $display("FAIL c25_done got %0d want 1", vif.done); end
    n_chk++; if (vif.change !== 8'd5) begin n_fail++; $display("FAIL c25_change got %0d want 5", vif.change); end
    repeat (3) tick();
    n_chk++; if (vif.balance !== 8'd50) begin n_fail++; $display("FAIL c25_bal_hold got %0d want 50", vif.balance); end
    n_chk++; if (vif.done !== 1'b1) begin n_fail++; $display("FAIL c25_done_hold got %0d want 1", vif.done); end
    vif.coin_sel = 2'b00;
  endtask

  task automatic test_mixed();
    logic [1:0] coins    [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
    int         exp_bal  [8] = '{0, 5, 10, 20, 30, 40, 50, 50};
    logic       exp_done [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    start_txn(2'b11);
    for (int i = 0; i < 8; i++) begin
      vif.coin_sel = coins[i];
      tick();
      n_chk++;
      if (vif.balance !== exp_bal[i][7:0]) begin
        n_fail++; $display("FAIL mix_bal[%0d] got %0d want %0d", i, vif.balance, exp_bal[i]);
      end
      n_chk++;
      if (vif.done !== exp_done[i]) begin
        n_fail++; $display("FAIL mix_done[%0d] got %0d want %0d", i, vif.done, exp_done[i]);
      end
    end
    vif.coin_sel = 2'b00;
    n_chk++; if (vif.change !== 8'd5) begin n_fail++; $display("FAIL mix_change got %0d want 5", vif.change); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_txn(2'b11);
    vif.coin_sel = 2'b10;
    tick(); tick();
    vif.coin_sel = 2'b00;
    tick();
    n_chk++; if (vif.balance !== 8'd20) begin n_fail++; $display("FAIL rm_bal20 got %0d want 20", vif.balance); end
    reset = 1'b1; vif.start = 1'b1;
    tick();
    reset = 1'b0; vif.start = 1'b0;
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL rm_bal got %0d want 0", vif.balance); end
    n_chk++; if (vif.price !== 8'd0) begin n_fail++; $display("FAIL rm_price got %0d want 0", vif.price); end
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rm_state got %0d want IDLE", dut.state); end
    n_chk++; if (dut.u_dp.item_q !== 2'b00) begin n_fail++; $display("FAIL rm_item got %0d want 0", dut.u_dp.item_q); end
    start_txn(2'b00);
    n_chk++; if (dut.state !== COLLECT) begin n_fail++; $display("FAIL rm_restart_state got %0d want COLLECT", dut.state); end
    n_chk++; if (vif.price !== 8'd15) begin n_fail++; $display("FAIL rm_restart_price got %0d want 15", vif.price); end
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL rm_restart_bal got %0d want 0", vif.balance); end
  endtask

  task automatic test_done_restart();
    do_reset();
    start_txn(2'b00);
    vif.coin_sel = 2'b11;
    tick();
    vif.coin_sel = 2'b00;
    tick(); tick();
    n_chk++; if (vif.done !== 1'b1) begin n_fail++; $display("FAIL dr_done got %0d want 1", vif.done); end
    n_chk++; if (vif.change !== 8'd10) begin n_fail++; $display("FAIL dr_change got %0d want 10", vif.change); end
    vif.item_sel = 2'b01; vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
    n_chk++; if (dut.state !== LOAD) begin n_fail++; $display("FAIL dr_state_load got %0d want LOAD", dut.state); end
    n_chk++; if (vif.done !== 1'b0) begin n_fail++; $display("FAIL dr_done_clr got %0d want 0", vif.done); end
    n_chk++; if (vif.change !== 8'd0) begin n_fail++; $display("FAIL dr_change_clr got %0d want 0", vif.change); end
    tick();
    n_chk++; if (vif.price !== 8'd20) begin n_fail++; $display("FAIL dr_price got %0d want 20", vif.price); end
    n_chk++; if (vif.balance !== 8'd0) begin n_fail++; $display("FAIL dr_bal got %0d want 0", vif.balance); end
    n_chk++; if (dut.state !== COLLECT) begin n_fail++; $display("FAIL dr_state_collect got %0d want COLLECT", dut.state); end
  endtask

  initial begin
    reset = 1'b1; vif.start = 1'b0; vif.item_sel = 2'b00; vif.coin_sel = 2'b00;
    test_reset();
    test_coin5();
    test_coin25();
    test_mixed();
    test_reset_mid();
    test_done_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
